fp_serial_sum: RTL and testbench
================================

Name: fp_serial_sum

Overview:
- Parametrised successor to the team's 4-operand serial FP adder: sums N_CH single-precision operands, each delivered bit-serially on its own lane.
- Adds per-lane enable/negate masks, accumulate mode, frame-error detection and a one-result holding buffer with a serial read-out handshake.
- Sits between the chip's serial pads and the host; one internal clock, no separate output clock.

Parameters:
- N_CH, 4, number of operand lanes (2..8)
- DATA_W, 32, operand/result width in bits; IEEE-754 binary32 layout (8-bit exponent, 23-bit mantissa)
- CFG_W, 2*N_CH+1, setup word width; must be <= DATA_W

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- serial_in  input  N_CH  operand lanes, LSB first; lane i = channel i
- wr_in  input  1  frame-valid strobe, high for DATA_W consecutive cycles
- setup_serial_in  input  1  setup bits, LSB first, during the last CFG_W cycles of the frame
- output_read_in  input  1  host request to shift out the held result
- input_rdy  output  1  block will accept a new frame
- output_rdy  output  1  result held and readable
- serial_out  output  1  result bit stream, LSB first
- frame_err  output  1  one-cycle pulse: frame aborted

Behaviour:
- Reset (async assert, sync release): state IDLE, input_rdy=1, output_rdy=0, serial_out=0, frame_err=0, bit counter=0, accumulator=+0.
- States: IDLE -> LOAD -> CALC -> HOLD -> SHIFT -> IDLE.
- IDLE: wr_in=1 while input_rdy=1 captures bit 0 and enters LOAD; input_rdy drops the next cycle.
- LOAD: one bit per lane per cycle into per-lane shift registers. Setup bits are captured at counts DATA_W-CFG_W..DATA_W-1.
  - Exactly DATA_W bits: go to CALC. wr_in held longer is ignored until it falls.
  - wr_in low before count DATA_W: discard the frame, pulse frame_err, return to IDLE.
- Setup word: bits [N_CH-1:0] = lane enable; [2N_CH-1:N_CH] = lane negate (sign flip); bit 2N_CH = accumulate.
- CALC: one lane per cycle, lane 0 to N_CH-1.
  - Start value is the accumulator if accumulate=1, else +0.
  - A disabled lane adds nothing.
  - Each step is one fp_add_comb result registered. output_rdy asserts exactly N_CH+1 cycles after the last LOAD cycle. The result is written to the accumulator.
- Arithmetic:
  - Truncation (round toward zero) at each step; order is fixed, not associative.
  - Denormal inputs are flushed to zero.
  - An exact zero result is +0.
  - Exponent overflow saturates to signed infinity (exp=0xFF, mantissa=0).
  - NaN/inf inputs are unsupported: undefined result, no hang.
- HOLD: output_rdy=1, result held indefinitely. output_read_in=1 sampled high enters SHIFT.
- SHIFT: serial_out = result bit k in the k-th cycle after the request edge, k=0..DATA_W-1. Shifting completes even if output_read_in drops. After bit DATA_W-1: output_rdy=0, input_rdy=1, state IDLE, serial_out=0.
- wr_in outside IDLE/LOAD is ignored. output_read_in outside HOLD is ignored.
- rst_in asserted in any state aborts immediately to reset values, including clearing the accumulator.

Decomposition:
- Package fp_serial_pkg: EXP_W=8, MAN_W=23, BIAS=127, state enum, setup-field offset functions of N_CH, FP_POS_ZERO/FP_INF constants.
- Sub-module fp_add_comb: combinational two-operand binary32 add. Does align, add/sub, leading-zero normalise, truncate, flush/saturate. The top-level owns the framing FSM, counters and registers.

Test Plan:
- Four lanes of 0x3F800000, setup enable=0xF, negate=0, acc=0 -> result 0x40800000; output_rdy exactly 5 cycles after the last LOAD cycle.
- Same operands, enable=0x3 -> 0x40000000. Lanes 0x42810000, 0x42010000, 0x41020000, 0x0, enable=0xF, negate=0x4 -> 0x42B14000.
- Accumulate: frame 4×0x3F800000 with acc=0, read out; then the same frame with acc=1 -> 0x41000000. A following frame with acc=0 -> 0x40800000.
- Overflow: lanes 0 and 1 = 0x7F7FFFFF, enable=0x3 -> 0x7F800000. Lane 0 = 0xBF800001 only -> 0xBF800001.
- Early abort: wr_in drops after 10 bits -> frame_err one-cycle pulse, input_rdy=1 on the next cycle, output_rdy never asserts. The next full frame computes correctly.
- Reset mid-SHIFT after 12 bits: all outputs at reset values immediately. A subsequent acc=1 frame of 4×1.0 -> 0x40800000 (accumulator cleared).

Source files
------------

// File: rtl/fp_serial_pkg.sv
// Shared types and constants for the bit-serial
// binary32 multi-lane summer.
package fp_serial_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_INF      = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_HOLD,
    S_SHIFT
  } state_t;

  function automatic int neg_lsb(input int n_ch);
    return n_ch;
  endfunction

  function automatic int acc_pos(input int n_ch);
    return 2 * n_ch;
  endfunction

endpackage

// File: rtl/fp_serial_sum_add.sv
// Combinational binary32 adder: truncating, flush-to-zero,
// saturating to signed infinity.
module fp_add_comb
  import fp_serial_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  localparam int FW = MAN_W + 4;

  logic              a_ge;
  logic [31:0]       big;
  logic [31:0]       sml;
  logic [EXP_W-1:0]  e_big;
  logic [EXP_W-1:0]  e_sml;
  logic [EXP_W-1:0]  d;
  logic [4:0]        dd;
  logic [FW-1:0]     m_big;
  logic [FW-1:0]     m_sml;
  logic [2*FW-1:0]   wide;
  logic [FW-1:0]     al;
  logic              sub;
  logic [FW:0]       res;
  logic [4:0]        lead;
  logic [4:0]        lz;
  logic [FW:0]       norm;
  logic [9:0]        ex;
  logic              uflow;

  always_comb begin
    y     = FP_POS_ZERO;
    a_ge  = a[30:0] >= b[30:0];
    big   = a_ge ? a : b;
    sml   = a_ge ? b : a;
    e_big = big[30:23];
    e_sml = sml[30:23];
    d     = e_big - e_sml;
    dd    = (d > 8'd27) ? 5'd27 : d[4:0];
    m_big = {1'b1, big[22:0], 3'b000};
    m_sml = {1'b1, sml[22:0], 3'b000};
    // bits shifted past the guard pair fold into a sticky LSB
    wide  = {m_sml, {FW{1'b0}}} >> dd;
    al    = wide[2*FW-1:FW];
    al[0] = al[0] | (|wide[FW-1:0]);
    sub   = big[31] ^ sml[31];
    res   = sub ? ({1'b0, m_big} - {1'b0, al})
                : ({1'b0, m_big} + {1'b0, al});
    lead  = 5'd0;
    for (int i = 0; i <= FW; i++) begin
      if (res[i]) lead = i[4:0];
    end
    lz    = 5'd0;
    uflow = 1'b0;
    if (res[FW]) begin
      norm = res >> 1;
      ex   = {2'b00, e_big} + 10'd1;
    end else begin
      lz    = 5'd26 - lead;
      norm  = res << lz;
      ex    = {2'b00, e_big} - {5'b0, lz};
      uflow = {5'b0, lz} >= {2'b00, e_big};
    end

    if (e_sml == '0) begin
      y = (e_big == '0) ? FP_POS_ZERO : big;
    end else if (res == '0) begin
      y = FP_POS_ZERO;
    end else if (uflow) begin
      y = FP_POS_ZERO;
    end else if (ex >= 10'd255) begin
      y = {big[31], FP_INF[30:0]};
    end else begin
      y = {big[31], ex[7:0], norm[25:3]};
    end
  end

endmodule

// File: rtl/fp_serial_sum.sv
// Bit-serial N_CH-lane binary32 summer with setup word,
// accumulate mode and serial result read-out.
module fp_serial_sum
  import fp_serial_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int CFG_W  = 2 * N_CH + 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] serial_in,
  input  logic            wr_in,
  input  logic            setup_serial_in,
  input  logic            output_read_in,
  output logic            input_rdy,
  output logic            output_rdy,
  output logic            serial_out,
  output logic            frame_err
);

  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int LANE_W  = $clog2(N_CH);
  localparam int NEG_LSB = neg_lsb(N_CH);
  localparam int ACC_POS = acc_pos(N_CH);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CFG_START = CNT_W'(DATA_W - CFG_W);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(DATA_W);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ops [N_CH];
  logic [CFG_W-1:0]  cfg;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] accum;
  logic [DATA_W-1:0] out_sr;
  logic              wr_block;
  logic              take;

  logic [LANE_W-1:0] lane;
  logic [N_CH-1:0]   en_mask;
  logic [N_CH-1:0]   neg_mask;
  logic [DATA_W-1:0] lane_op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] add_y;
  logic [DATA_W-1:0] step;

  assign input_rdy  = (state == S_IDLE);
  assign output_rdy = (state == S_HOLD) || (state == S_SHIFT);

  assign take = wr_in && (((state == S_IDLE) && !wr_block)
                          || (state == S_LOAD));

  assign lane     = cnt[LANE_W-1:0];
  assign en_mask  = cfg[N_CH-1:0];
  assign neg_mask = cfg[NEG_LSB +: N_CH];
  assign lane_op  = ops[lane];
  assign op_a     = (cnt == '0)
                    ? (cfg[ACC_POS] ? accum : FP_POS_ZERO)
                    : sum;
  assign op_b     = {lane_op[DATA_W-1] ^ neg_mask[lane],
                     lane_op[DATA_W-2:0]};
  assign step     = en_mask[lane] ? add_y : op_a;

  fp_add_comb u_add (
    .a (op_a),
    .b (op_b),
    .y (add_y)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (wr_in && !wr_block) state_nx = S_LOAD;
      S_LOAD: begin
        if (!wr_in)                state_nx = S_IDLE;
        else if (cnt == LAST_BIT)  state_nx = S_CALC;
      end
      S_CALC:  if (cnt == LAST_LANE) state_nx = S_HOLD;
      S_HOLD:  if (output_read_in)   state_nx = S_SHIFT;
      S_SHIFT: if (cnt == SHIFT_END) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt        <= '0;
      cfg        <= '0;
      sum        <= '0;
      accum      <= FP_POS_ZERO;
      out_sr     <= '0;
      wr_block   <= 1'b0;
      serial_out <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < N_CH; i++) ops[i] <= '0;
    end else begin
      frame_err <= 1'b0;
      if (!wr_in) wr_block <= 1'b0;
      if (take) begin
        for (int i = 0; i < N_CH; i++)
          ops[i] <= {serial_in[i], ops[i][DATA_W-1:1]};
        if (cnt >= CFG_START)
          cfg <= {setup_serial_in, cfg[CFG_W-1:1]};
      end
      unique case (state)
        S_IDLE: if (take) cnt <= CNT_W'(1);
        S_LOAD: begin
          if (!wr_in) begin
            frame_err <= 1'b1;
            cnt       <= '0;
          end else if (cnt == LAST_BIT) begin
            // a wr_in still high must fall before the next frame
            cnt      <= '0;
            wr_block <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CALC: begin
          sum <= step;
          if (cnt == LAST_LANE) begin
            accum <= step;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (output_read_in) begin
            serial_out <= sum[0];
            out_sr     <= sum >> 1;
            cnt        <= CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (cnt == SHIFT_END) begin
            serial_out <= 1'b0;
            cnt        <= '0;
          end else begin
            serial_out <= out_sr[0];
            out_sr     <= out_sr >> 1;
            cnt        <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_serial_sum.sv
// Directed bench for fp_serial_sum: framing, arithmetic,
// accumulate, abort and reset behaviour.
module tb_fp_serial_sum;

  localparam int N = 4;
  localparam int W = 32;
  localparam int CW = 2 * N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sin = '0;
  logic         wr = 1'b0;
  logic         setup = 1'b0;
  logic         rd = 1'b0;
  logic         irdy;
  logic         ordy;
  logic         sout;
  logic         ferr;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] ONES4 =
    {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};

  always #5 clk = ~clk;

  fp_serial_sum #(.N_CH(N), .DATA_W(W)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .serial_in       (sin),
    .wr_in           (wr),
    .setup_serial_in (setup),
    .output_read_in  (rd),
    .input_rdy       (irdy),
    .output_rdy      (ordy),
    .serial_out      (sout),
    .frame_err       (ferr)
  );

  function automatic logic [CW-1:0] mk_cfg(
    input logic [N-1:0] en,
    input logic [N-1:0] neg,
    input logic acc
  );
    return {acc, neg, en};
  endfunction

  task automatic drive_bits(
    input logic [127:0] lanes,
    input logic [CW-1:0] cfg,
    input int nbits
  );
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      wr = 1'b1;
      for (int i = 0; i < N; i++) sin[i] = lanes[32*i + k];
      setup = (k >= W - CW) ? cfg[k - (W - CW)] : 1'b0;
    end
    @(negedge clk);
    wr = 1'b0;
    sin = '0;
    setup = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 1;
    while (!ordy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read_out(output logic [31:0] r);
    rd = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      rd = 1'b0;
      r[k] = sout;
    end
  endtask

  task automatic run_frame(
    input logic [127:0] lanes,
    input logic [CW-1:0] cfg,
    output int lat,
    output logic [31:0] r
  );
    drive_bits(lanes, cfg, W);
    wait_rdy(lat);
    read_out(r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({irdy, ordy, sout, ferr} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_outs got=%b want=1000",
               {irdy, ordy, sout, ferr});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sum4();
    int lat;
    logic [31:0] r;
    run_frame(ONES4, mk_cfg(4'hF, 4'h0, 1'b0), lat, r);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL sum4_latency got=%0d want=5", lat);
    end
    total++;
    if (r !== 32'h40800000) begin
      bad++;
      $display("FAIL sum4_result got=%h want=40800000", r);
    end
    @(negedge clk);
    total++;
    if ({irdy, ordy, sout} !== 3'b100) begin
      bad++;
      $display("FAIL sum4_idle got=%b want=100",
               {irdy, ordy, sout});
    end
  endtask

  task automatic test_enable();
    int lat;
    logic [31:0] r;
    run_frame(ONES4, mk_cfg(4'h3, 4'h0, 1'b0), lat, r);
    total++;
    if (r !== 32'h40000000) begin
      bad++;
      $display("FAIL enable_result got=%h want=40000000", r);
    end
  endtask

  task automatic test_negate();
    int lat;
    logic [31:0] r;
    run_frame({32'h0, 32'h41020000, 32'h42010000, 32'h42810000},
              mk_cfg(4'hF, 4'h4, 1'b0), lat, r);
    total++;
    if (r !== 32'h42B14000) begin
      bad++;
      $display("FAIL negate_result got=%h want=42B14000", r);
    end
  endtask

  task automatic test_accumulate();
    int lat;
    logic [31:0] r;
    run_frame(ONES4, mk_cfg(4'hF, 4'h0, 1'b0), lat, r);
    total++;
    if (r !== 32'h40800000) begin
      bad++;
      $display("FAIL acc_first got=%h want=40800000", r);
    end
    run_frame(ONES4, mk_cfg(4'hF, 4'h0, 1'b1), lat, r);
    total++;
    if (r !== 32'h41000000) begin
      bad++;
      $display("FAIL acc_second got=%h want=41000000", r);
    end
    run_frame(ONES4, mk_cfg(4'hF, 4'h0, 1'b0), lat, r);
    total++;
    if (r !== 32'h40800000) begin
      bad++;
      $display("FAIL acc_cleared got=%h want=40800000", r);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] r;
    run_frame({32'h3F800000, 32'h3F800000,
               32'h7F7FFFFF, 32'h7F7FFFFF},
              mk_cfg(4'h3, 4'h0, 1'b0), lat, r);
    total++;
    if (r !== 32'h7F800000) begin
      bad++;
      $display("FAIL overflow got=%h want=7F800000", r);
    end
    run_frame({32'h3F800000, 32'h3F800000,
               32'h3F800000, 32'hBF800001},
              mk_cfg(4'h1, 4'h0, 1'b0), lat, r);
    total++;
    if (r !== 32'hBF800001) begin
      bad++;
      $display("FAIL single_lane got=%h want=BF800001", r);
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [31:0] r;
    drive_bits(ONES4, mk_cfg(4'h7, 4'h0, 1'b0), W);
    wait_rdy(lat);
    wr = 1'b1;
    sin = '1;
    repeat (8) @(negedge clk);
    total++;
    if ({irdy, ordy} !== 2'b01) begin
      bad++;
      $display("FAIL hold_state got=%b want=01", {irdy, ordy});
    end
    wr = 1'b0;
    sin = '0;
    read_out(r);
    total++;
    if (r !== 32'h40400000) begin
      bad++;
      $display("FAIL hold_result got=%h want=40400000", r);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] r;
    drive_bits(ONES4, mk_cfg(4'hF, 4'h0, 1'b0), 10);
    @(negedge clk);
    total++;
    if ({ferr, irdy, ordy} !== 3'b110) begin
      bad++;
      $display("FAIL abort_pulse got=%b want=110",
               {ferr, irdy, ordy});
    end
    @(negedge clk);
    total++;
    if ({ferr, ordy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_after got=%b want=00", {ferr, ordy});
    end
    run_frame({32'h3F800000, 32'h3F800000,
               32'h40000000, 32'h3F800000},
              mk_cfg(4'hF, 4'h0, 1'b0), lat, r);
    total++;
    if (r !== 32'h40A00000) begin
      bad++;
      $display("FAIL abort_next got=%h want=40A00000", r);
    end
  endtask

  task automatic test_reset_shift();
    int lat;
    logic [31:0] r;
    drive_bits(ONES4, mk_cfg(4'hF, 4'h0, 1'b0), W);
    wait_rdy(lat);
    rd = 1'b1;
    repeat (12) begin
      @(negedge clk);
      rd = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({irdy, ordy, sout, ferr} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_shift got=%b want=1000",
               {irdy, ordy, sout, ferr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(ONES4, mk_cfg(4'hF, 4'h0, 1'b1), lat, r);
    total++;
    if (r !== 32'h40800000) begin
      bad++;
      $display("FAIL reset_acc got=%h want=40800000", r);
    end
  endtask

  initial begin
    test_reset();
    test_sum4();
    test_enable();
    test_negate();
    test_accumulate();
    test_overflow();
    test_hold();
    test_abort();
    test_reset_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
